// File: rtl/delay_line_prog.sv
// Multi-channel programmable delay line with clock enable, fill-valid tracking and clamped delay reload.
// Optional DELAY_SYNC_EN adds a two-flop input synchroniser ahead of the delay stages.
module delay_line_prog #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned NCH         = 32,
  parameter int unsigned MAX_DEPTH   = 16,
  parameter int unsigned DLY_W       = 5,
  parameter int unsigned DEFAULT_DLY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NCH*WIDTH-1:0]   din,
  input  logic [DLY_W-1:0]       dly,
  input  logic                   dly_load,
  output logic [NCH*WIDTH-1:0]   dout,
  output logic                   dout_valid,
  output logic [DLY_W-1:0]       dly_cur,
  output logic                   dly_err
);

  localparam int unsigned BUS_W  = NCH * WIDTH;
  localparam int unsigned FILL_W = $clog2(MAX_DEPTH + 2);

  logic [BUS_W-1:0]  din_s;
  logic [BUS_W-1:0]  stage_q [MAX_DEPTH];
  logic [BUS_W-1:0]  stage_d [MAX_DEPTH];
  logic [BUS_W-1:0]  dout_q, dout_d;
  logic [BUS_W-1:0]  tap;
  logic [FILL_W-1:0] fill_q, fill_d, fill_tgt;
  logic              valid_q, valid_d;
  logic [DLY_W-1:0]  dly_cur_q, dly_cur_d;
  logic              err_q, err_d;

`ifdef DELAY_SYNC_EN
  logic [BUS_W-1:0] sync1_q, sync2_q;

  // Free-running synchroniser: not gated by en, so it keeps sampling while the line is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  assign din_s = sync2_q;
`else
  assign din_s = din;
`endif

  // Output tap selected by the delay in effect before this edge.
  always_comb begin
    tap = din_s;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (dly_cur_q == DLY_W'(i + 1)) tap = stage_q[i];
    end
  end

  always_comb begin
    stage_d   = stage_q;
    dout_d    = dout_q;
    fill_d    = fill_q;
    valid_d   = valid_q;
    dly_cur_d = dly_cur_q;
    err_d     = 1'b0;
    fill_tgt  = FILL_W'(dly_cur_q) + FILL_W'(1);

    if (en) begin
      stage_d[0] = din_s;
      for (int unsigned i = 1; i < MAX_DEPTH; i++) stage_d[i] = stage_q[i-1];
      dout_d = tap;
      if (fill_q < fill_tgt) fill_d = fill_q + FILL_W'(1);
      valid_d = (fill_d == fill_tgt);
    end

    // A load overrides fill tracking even on an enabled edge; the shift above still used the old delay.
    if (dly_load) begin
      err_d     = (dly > DLY_W'(MAX_DEPTH));
      dly_cur_d = err_d ? DLY_W'(MAX_DEPTH) : dly;
      fill_d    = '0;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_DEPTH; i++) stage_q[i] <= '0;
      dout_q    <= '0;
      fill_q    <= '0;
      valid_q   <= 1'b0;
      dly_cur_q <= DLY_W'(DEFAULT_DLY);
      err_q     <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      dout_q    <= dout_d;
      fill_q    <= fill_d;
      valid_q   <= valid_d;
      dly_cur_q <= dly_cur_d;
      err_q     <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dly_cur    = dly_cur_q;
  assign dly_err    = err_q;

endmodule

// File: tb/tb_delay_line_prog.sv
// Scoreboard bench for delay_line_prog: a history-queue reference model predicts every post-edge output.
module tb_delay_line_prog;

  localparam int unsigned NCH       = 32;
  localparam int unsigned WIDTH     = 1;
  localparam int unsigned BUS_W     = NCH * WIDTH;
  localparam int unsigned MAX_DEPTH = 16;
  localparam int unsigned DLY_W     = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             dly_load;
  logic [DLY_W-1:0] dly;
  logic [BUS_W-1:0] din;
  logic [BUS_W-1:0] dout;
  logic             dout_valid;
  logic [DLY_W-1:0] dly_cur;
  logic             dly_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  delay_line_prog #(
    .WIDTH(WIDTH), .NCH(NCH), .MAX_DEPTH(MAX_DEPTH), .DLY_W(DLY_W), .DEFAULT_DLY(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .dly(dly), .dly_load(dly_load),
    .dout(dout), .dout_valid(dout_valid), .dly_cur(dly_cur), .dly_err(dly_err)
  );

  typedef struct packed {
    logic [BUS_W-1:0] dout;
    logic             valid;
    logic [DLY_W-1:0] cur;
    logic             err;
  } exp_t;

  exp_t             sb_q[$];
  logic [BUS_W-1:0] hist[$];   // enabled-edge samples, most recent first
  int               m_cur;
  int               m_cnt;
  logic [BUS_W-1:0] m_dout;
  logic [BUS_W-1:0] syn1, syn2;

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < int'(MAX_DEPTH); i++) hist.push_back('0);
    m_cur  = 1;
    m_cnt  = 0;
    m_dout = '0;
    syn1   = '0;
    syn2   = '0;
  endfunction

  // Reference model: predicts outputs after each edge and queues them.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      sb_q.delete();
    end else begin
      logic [BUS_W-1:0] d_eff;
      exp_t             e;
`ifdef DELAY_SYNC_EN
      d_eff = syn2;
      syn2  = syn1;
      syn1  = din;
`else
      d_eff = din;
`endif
      if (en) begin
        m_dout = (m_cur == 0) ? d_eff : hist[m_cur-1];
        hist.push_front(d_eff);
        void'(hist.pop_back());
        m_cnt++;
      end
      e.err = 1'b0;
      if (dly_load) begin
        e.err = (int'(dly) > int'(MAX_DEPTH));
        m_cur = e.err ? int'(MAX_DEPTH) : int'(dly);
        m_cnt = 0;
      end
      e.dout  = m_dout;
      e.valid = (m_cnt > m_cur);
      e.cur   = DLY_W'(m_cur);
      sb_q.push_back(e);
    end
  end

  // Monitor: compares each post-edge output against the queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("dout",       dout,                   e.dout);
      chk("dout_valid", BUS_W'(dout_valid),     BUS_W'(e.valid));
      chk("dly_cur",    BUS_W'(dly_cur),        BUS_W'(e.cur));
      chk("dly_err",    BUS_W'(dly_err),        BUS_W'(e.err));
    end
  end

  task automatic step(input logic e, input logic l, input logic [DLY_W-1:0] d, input logic [BUS_W-1:0] x);
    @(negedge clk);
    en       = e;
    dly_load = l;
    dly      = d;
    din      = x;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_dout"},    dout,               '0);
    chk({tag, "_valid"},   BUS_W'(dout_valid), '0);
    chk({tag, "_dly_cur"}, BUS_W'(dly_cur),    BUS_W'(1));
    chk({tag, "_dly_err"}, BUS_W'(dly_err),    '0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dly_load = 1'b0; dly = '0; din = '0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Default delay, ch0 pattern 1,0,1,1
    step(1, 0, 0, BUS_W'(1));
    step(1, 0, 0, BUS_W'(0));
    step(1, 0, 0, BUS_W'(1));
    step(1, 0, 0, BUS_W'(1));
    repeat (4) step(1, 0, 0, '0);

    // Delay 7, single pulse on ch31
    step(1, 1, 7, '0);
    repeat (2) step(1, 0, 0, '0);
    step(1, 0, 0, BUS_W'(32'h8000_0000));
    repeat (12) step(1, 0, 0, '0);

    // Delay 3, alternating enable with ramp data
    step(1, 1, 3, '0);
    for (int i = 0; i < 24; i++) step(logic'(i % 2 == 0), 0, 0, BUS_W'(i + 1));

    // Clamp to MAX_DEPTH, then zero delay
    step(1, 1, 31, BUS_W'($urandom));
    repeat (20) step(1, 0, 0, BUS_W'($urandom));
    step(1, 1, 0, BUS_W'($urandom));
    repeat (5) step(1, 0, 0, BUS_W'($urandom));

    // Simultaneous load and enable
    step(1, 1, 2, BUS_W'($urandom));
    repeat (5) step(1, 0, 0, BUS_W'($urandom));
    step(1, 1, 5, BUS_W'($urandom));
    repeat (10) step(1, 0, 0, BUS_W'($urandom));

    // Async reset mid-operation with delay 9 and valid high
    step(1, 1, 9, BUS_W'($urandom));
    repeat (15) step(1, 0, 0, BUS_W'($urandom));
    @(posedge clk);
    #2;
    rst = 1'b1;
    dly_load = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic with occasional reloads
    for (int i = 0; i < 400; i++)
      step(logic'(($urandom % 4) != 0), logic'(($urandom % 20) == 0), DLY_W'($urandom), BUS_W'($urandom));

    step(0, 0, 0, '0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
